mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 148 ++++++++++++++
 tb/tb_mem_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: two requesters share one memory port, with one access in flight at a time (IDLE->ISSUE->WAIT->RESP).
// Latency: grant at edge e0, strobe during e0..e1, rN_ready one cycle after the matching mem ready is sampled.
// Backpressure: WAIT holds indefinitely for the matching mem ready; requests are only sampled in IDLE.
// Config: define MEM_ARB_ROUND_ROBIN_EN for round-robin ties; otherwise requester 0 has fixed priority.
`ifndef DEFAULT_MADDR_WIDTH
`define DEFAULT_MADDR_WIDTH 8
`endif
`ifndef DEFAULT_MDATA_WIDTH
`define DEFAULT_MDATA_WIDTH 8
`endif

module mem_arbiter #(
   parameter int MADDR_WIDTH = `DEFAULT_MADDR_WIDTH,
   parameter int MDATA_WIDTH = `DEFAULT_MDATA_WIDTH
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   r0_read_enable,
   input  logic                   r0_write_enable,
   input  logic [MADDR_WIDTH-1:0] r0_addr,
   input  logic [MDATA_WIDTH-1:0] r0_write_data,
   output logic [MDATA_WIDTH-1:0] r0_read_data,
   output logic                   r0_ready,
   input  logic                   r1_read_enable,
   input  logic                   r1_write_enable,
   input  logic [MADDR_WIDTH-1:0] r1_addr,
   input  logic [MDATA_WIDTH-1:0] r1_write_data,
   output logic [MDATA_WIDTH-1:0] r1_read_data,
   output logic                   r1_ready,
   output logic                   mem_read_enable,
   output logic                   mem_write_enable,
   output logic [MADDR_WIDTH-1:0] mem_addr,
   output logic [MDATA_WIDTH-1:0] mem_write_data,
   input  logic                   mem_read_ready,
   input  logic                   mem_write_ready,
   input  logic [MDATA_WIDTH-1:0] mem_read_data,
   output logic                   busy
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t                   state_q, state_d;
   logic                     grant_q, grant_d;     // 0 = requester 0, 1 = requester 1
   logic                     op_wr_q, op_wr_d;     // latched operation: 1 = write
   logic [MADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [MDATA_WIDTH-1:0]   wdata_q, wdata_d;
   logic [MDATA_WIDTH-1:0]   rdata0_q, rdata0_d;
   logic [MDATA_WIDTH-1:0]   rdata1_q, rdata1_d;
   logic                     pend0, pend1, pick;

   assign pend0 = r0_read_enable | r0_write_enable;
   assign pend1 = r1_read_enable | r1_write_enable;

`ifdef MEM_ARB_ROUND_ROBIN_EN
   logic rr_ptr_q, rr_ptr_d;   // requester that wins the next tie

   // Tie goes to the pointer; a lone requester always wins.
   always_comb begin
      pick = !pend0;
      if (pend0 && pend1) pick = rr_ptr_q;
   end

   // Pointer moves to the other requester on every grant.
   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (state_q == IDLE && (pend0 || pend1)) rr_ptr_d = ~pick;
   end

   // Round-robin pointer register; points to requester 0 out of reset.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) rr_ptr_q <= 1'b0;
      else       rr_ptr_q <= rr_ptr_d;
   end
`else
   // Fixed priority: requester 0 wins any tie.
   always_comb begin
      pick = !pend0;
   end
`endif

   // Next-state and datapath-load logic for the access FSM.
   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      op_wr_d  = op_wr_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rdata0_d = rdata0_q;
      rdata1_d = rdata1_q;
      case (state_q)
         IDLE: begin
            if (pend0 || pend1) begin
               grant_d = pick;
               // Write wins over a simultaneous read from the same requester.
               op_wr_d = pick ? r1_write_enable : r0_write_enable;
               addr_d  = pick ? r1_addr : r0_addr;
               wdata_d = pick ? r1_write_data : r0_write_data;
               state_d = ISSUE;
            end
         end
         ISSUE: state_d = WAIT;
         WAIT: begin
            // Only the ready matching the latched operation completes it.
            if (op_wr_q ? mem_write_ready : mem_read_ready) begin
               state_d = RESP;
               if (!op_wr_q) begin
                  if (grant_q) rdata1_d = mem_read_data;
                  else         rdata0_d = mem_read_data;
               end
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers; reset aborts any transaction in flight.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         grant_q  <= 1'b0;
         op_wr_q  <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata0_q <= '0;
         rdata1_q <= '0;
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         op_wr_q  <= op_wr_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         rdata0_q <= rdata0_d;
         rdata1_q <= rdata1_d;
      end
   end

   assign mem_read_enable  = (state_q == ISSUE) && !op_wr_q;
   assign mem_write_enable = (state_q == ISSUE) &&  op_wr_q;
   assign mem_addr         = addr_q;
   assign mem_write_data   = wdata_q;
   assign r0_ready         = (state_q == RESP) && !grant_q;
   assign r1_ready         = (state_q == RESP) &&  grant_q;
   assign r0_read_data     = rdata0_q;
   assign r1_read_data     = rdata1_q;
   assign busy             = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed transaction table plus hand sequences for reset behaviour.
// Inputs are driven 1 time unit after the rising edge; outputs are checked at the same point.
// The memory side is a small array that answers each access after a per-vector delay.
module tb_mem_arbiter;

   logic       clock, reset;
   logic       r0_read_enable, r0_write_enable, r1_read_enable, r1_write_enable;
   logic [7:0] r0_addr, r0_write_data, r1_addr, r1_write_data;
   logic [7:0] r0_read_data, r1_read_data;
   logic       r0_ready, r1_ready;
   logic       mem_read_enable, mem_write_enable, mem_read_ready, mem_write_ready;
   logic [7:0] mem_addr, mem_write_data, mem_read_data;
   logic       busy;

   mem_arbiter dut (
      .clock(clock), .reset(reset),
      .r0_read_enable(r0_read_enable), .r0_write_enable(r0_write_enable),
      .r0_addr(r0_addr), .r0_write_data(r0_write_data),
      .r0_read_data(r0_read_data), .r0_ready(r0_ready),
      .r1_read_enable(r1_read_enable), .r1_write_enable(r1_write_enable),
      .r1_addr(r1_addr), .r1_write_data(r1_write_data),
      .r1_read_data(r1_read_data), .r1_ready(r1_ready),
      .mem_read_enable(mem_read_enable), .mem_write_enable(mem_write_enable),
      .mem_addr(mem_addr), .mem_write_data(mem_write_data),
      .mem_read_ready(mem_read_ready), .mem_write_ready(mem_write_ready),
      .mem_read_data(mem_read_data), .busy(busy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic       r0_rd, r0_wr;
      logic [7:0] r0_a, r0_wd;
      logic       r1_rd, r1_wr;
      logic [7:0] r1_a, r1_wd;
      int         wait_cyc;   // cycles in WAIT before the matching ready
      logic       mism;       // drive the wrong ready during those cycles
      logic       drop;       // release requests during RESP
      logic       exp_gnt;
      logic       exp_wr;
      logic [7:0] exp_addr, exp_wd, exp_rd;
   } vec_t;

   int         checks = 0;
   int         failures = 0;
   logic [7:0] mem [256];
   logic [7:0] exp_rd0, exp_rd1;
   vec_t       vecs [10];
   vec_t       fin;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(input logic r0rd, r0wr, input logic [7:0] r0a, r0wd,
                               input logic r1rd, r1wr, input logic [7:0] r1a, r1wd,
                               input int wc, input logic mm, dr, eg, ew,
                               input logic [7:0] ea, ewd, erd);
      vec_t v;
      v.r0_rd = r0rd; v.r0_wr = r0wr; v.r0_a = r0a; v.r0_wd = r0wd;
      v.r1_rd = r1rd; v.r1_wr = r1wr; v.r1_a = r1a; v.r1_wd = r1wd;
      v.wait_cyc = wc; v.mism = mm; v.drop = dr;
      v.exp_gnt = eg; v.exp_wr = ew; v.exp_addr = ea; v.exp_wd = ewd; v.exp_rd = erd;
      return v;
   endfunction

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_en"}, {mem_read_enable, mem_write_enable}, 0);
      chk({tag, "_addr"}, mem_addr, 0);
      chk({tag, "_wdata"}, mem_write_data, 0);
      chk({tag, "_ready"}, {r1_ready, r0_ready}, 0);
      chk({tag, "_rdata0"}, r0_read_data, 0);
      chk({tag, "_rdata1"}, r1_read_data, 0);
   endtask

   // One full transaction: apply requests in IDLE, then check every cycle to IDLE again.
   task automatic run_vec(input vec_t v);
      r0_read_enable = v.r0_rd; r0_write_enable = v.r0_wr; r0_addr = v.r0_a; r0_write_data = v.r0_wd;
      r1_read_enable = v.r1_rd; r1_write_enable = v.r1_wr; r1_addr = v.r1_a; r1_write_data = v.r1_wd;
      step();
      chk("issue_busy", busy, 1);
      chk("issue_wen", mem_write_enable, v.exp_wr);
      chk("issue_ren", mem_read_enable, !v.exp_wr);
      chk("issue_addr", mem_addr, v.exp_addr);
      chk("issue_ready", {r1_ready, r0_ready}, 0);
      if (v.exp_wr) begin
         chk("issue_wdata", mem_write_data, v.exp_wd);
         mem[mem_addr] = mem_write_data;
      end
      step();
      for (int i = 0; i < v.wait_cyc; i++) begin
         chk("wait_en", {mem_read_enable, mem_write_enable}, 0);
         chk("wait_busy", busy, 1);
         chk("wait_ready", {r1_ready, r0_ready}, 0);
         if (v.mism) begin
            mem_write_ready = !v.exp_wr;
            mem_read_ready  = v.exp_wr;
         end
         step();
      end
      chk("wait_en", {mem_read_enable, mem_write_enable}, 0);
      chk("wait_busy", busy, 1);
      chk("wait_ready", {r1_ready, r0_ready}, 0);
      mem_write_ready = v.exp_wr;
      mem_read_ready  = !v.exp_wr;
      mem_read_data   = mem[mem_addr];
      step();
      mem_write_ready = 1'b0;
      mem_read_ready  = 1'b0;
      mem_read_data   = 8'hEE;
      if (!v.exp_wr) begin
         if (v.exp_gnt) exp_rd1 = v.exp_rd;
         else           exp_rd0 = v.exp_rd;
      end
      chk("resp_r0_ready", r0_ready, !v.exp_gnt);
      chk("resp_r1_ready", r1_ready, v.exp_gnt);
      chk("resp_busy", busy, 1);
      chk("resp_en", {mem_read_enable, mem_write_enable}, 0);
      chk("resp_r0_data", r0_read_data, exp_rd0);
      chk("resp_r1_data", r1_read_data, exp_rd1);
      if (v.drop) begin
         r0_read_enable = 0; r0_write_enable = 0;
         r1_read_enable = 0; r1_write_enable = 0;
      end
      step();
      chk("idle_busy", busy, 0);
      chk("idle_ready", {r1_ready, r0_ready}, 0);
      chk("idle_r0_data", r0_read_data, exp_rd0);
      chk("idle_r1_data", r1_read_data, exp_rd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
      exp_rd0 = 8'h00;
      exp_rd1 = 8'h00;

      //           r0 rd wr addr   wdata  r1 rd wr addr   wdata  wait mism drop gnt wr addr   wdata  rdata
      vecs[0] = mk(1, 1, 8'h20, 8'h3C, 0, 0, 8'h00, 8'h00, 0,   0,   1,   0,  1, 8'h20, 8'h3C, 8'h00);
      vecs[1] = mk(0, 1, 8'h10, 8'hA5, 0, 0, 8'h00, 8'h00, 0,   0,   1,   0,  1, 8'h10, 8'hA5, 8'h00);
      vecs[2] = mk(0, 0, 8'h00, 8'h00, 1, 0, 8'h10, 8'h00, 0,   0,   1,   1,  0, 8'h10, 8'h00, 8'hA5);
`ifdef MEM_ARB_ROUND_ROBIN_EN
      vecs[3] = mk(1, 0, 8'h20, 8'h00, 1, 0, 8'h30, 8'h00, 0,   0,   0,   0,  0, 8'h20, 8'h00, 8'h3C);
      vecs[4] = mk(1, 0, 8'h20, 8'h00, 1, 0, 8'h30, 8'h00, 0,   0,   0,   1,  0, 8'h30, 8'h00, 8'h6A);
      vecs[5] = mk(1, 0, 8'h20, 8'h00, 1, 0, 8'h30, 8'h00, 0,   0,   0,   0,  0, 8'h20, 8'h00, 8'h3C);
      vecs[6] = mk(1, 0, 8'h20, 8'h00, 1, 0, 8'h30, 8'h00, 0,   0,   1,   1,  0, 8'h30, 8'h00, 8'h6A);
`else
      vecs[3] = mk(1, 0, 8'h20, 8'h00, 1, 0, 8'h30, 8'h00, 0,   0,   0,   0,  0, 8'h20, 8'h00, 8'h3C);
      vecs[4] = mk(1, 0, 8'h20, 8'h00, 1, 0, 8'h30, 8'h00, 0,   0,   0,   0,  0, 8'h20, 8'h00, 8'h3C);
      vecs[5] = mk(1, 0, 8'h20, 8'h00, 1, 0, 8'h30, 8'h00, 0,   0,   0,   0,  0, 8'h20, 8'h00, 8'h3C);
      vecs[6] = mk(1, 0, 8'h20, 8'h00, 1, 0, 8'h30, 8'h00, 0,   0,   1,   0,  0, 8'h20, 8'h00, 8'h3C);
`endif
      vecs[7] = mk(1, 0, 8'h44, 8'h00, 0, 0, 8'h00, 8'h00, 3,   1,   1,   0,  0, 8'h44, 8'h00, 8'h1E);
      vecs[8] = mk(1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00, 10,  0,   1,   0,  0, 8'h10, 8'h00, 8'hA5);
      vecs[9] = mk(0, 0, 8'h00, 8'h00, 0, 1, 8'h55, 8'h99, 2,   1,   1,   1,  1, 8'h55, 8'h99, 8'h00);

      reset = 1'b1;
      r0_read_enable = 0; r0_write_enable = 0; r0_addr = 0; r0_write_data = 0;
      r1_read_enable = 0; r1_write_enable = 0; r1_addr = 0; r1_write_data = 0;
      mem_read_ready = 0; mem_write_ready = 0; mem_read_data = 8'hEE;
      step();
      step();
      chk_all_zero("reset");
      reset = 1'b0;
      step();
      chk_all_zero("post_reset");

      for (int i = 0; i < 10; i++) run_vec(vecs[i]);

      // Reset pulsed while the transaction sits in WAIT.
      r1_read_enable = 1; r1_addr = 8'h10;
      step();
      chk("abort_issue_ren", mem_read_enable, 1);
      step();
      chk("abort_wait_busy", busy, 1);
      #2;
      reset = 1'b1;
      #1;
      chk_all_zero("async_reset");
      r1_read_enable = 0;
      mem_read_ready = 1;
      step();
      reset = 1'b0;
      exp_rd0 = 8'h00;
      exp_rd1 = 8'h00;
      for (int i = 0; i < 3; i++) begin
         chk("abort_no_ready", {r1_ready, r0_ready}, 0);
         chk("abort_idle", busy, 0);
         step();
      end
      mem_read_ready = 0;

      // The next request after the abort completes normally.
      fin = mk(1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00, 1, 0, 1, 0, 0, 8'h10, 8'h00, 8'hA5);
      run_vec(fin);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
